reg_file_rd: RTL and testbench

- Read side of the CPU's architectural state: a 32-entry integer register file with two combinational read ports, one write-back port and a per-register pending-write scoreboard.
- Sits between decode/issue and write-back.
- Supplies operands with a write-back bypass and raises `stall` on RAW and WAW hazards against in-flight writes.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/reg_file_rd_if.sv | 50 +++++
 rtl/reg_file_rd_scoreboard.sv | 120 ++++++++++++
 rtl/reg_file_rd.sv | 67 ++++++
 tb/tb_reg_file_rd.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the integer register file read side.
//   XLEN     : register data width
//   NREGS    : number of architectural registers (x0 included)
//   AW       : register address width, 2**AW == NREGS
//   ZERO_REG : index of the hard-wired zero register
//   sb_entry_t : one scoreboard entry. With REGFILE_PENDING_CNT_EN defined it
//                is a 2-bit saturating in-flight counter, otherwise a single
//                busy bit.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    localparam logic [AW-1:0] ZERO_REG = '0;

`ifdef REGFILE_PENDING_CNT_EN
    typedef logic [1:0] sb_entry_t;
    localparam sb_entry_t SB_MAX = 2'd3;
`else
    typedef logic sb_entry_t;
`endif

endpackage

// File: rtl/reg_file_rd_if.sv
// -----------------------------------------------------------------------------
// reg_file_rd_if
// Decode/issue and write-back signals of the register file read side.
//   master : decode/issue + write-back stage (drives addresses, issue, wb)
//   slave  : register file (returns operands, busy flags, stall, issue_ack)
// Signals:
//   rs1_addr/rs1_used, rs2_addr/rs2_used : source operand selects
//   rs1_data/rs2_data                    : source operands (combinational)
//   issue_valid/issue_rd/issue_ack       : destination issue handshake
//   wb_valid/wb_addr/wb_data             : write-back port
//   rs1_busy/rs2_busy/stall              : hazard indications
// -----------------------------------------------------------------------------
interface reg_file_rd_if #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int AW   = cpu_pkg::AW
);
    logic [AW-1:0]   rs1_addr;
    logic            rs1_used;
    logic [AW-1:0]   rs2_addr;
    logic            rs2_used;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ack;

    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            rs1_busy;
    logic            rs2_busy;
    logic            stall;

    modport master (
        output rs1_addr, rs1_used, rs2_addr, rs2_used,
        output issue_valid, issue_rd,
        output wb_valid, wb_addr, wb_data,
        input  rs1_data, rs2_data, issue_ack, rs1_busy, rs2_busy, stall
    );

    modport slave (
        input  rs1_addr, rs1_used, rs2_addr, rs2_used,
        input  issue_valid, issue_rd,
        input  wb_valid, wb_addr, wb_data,
        output rs1_data, rs2_data, issue_ack, rs1_busy, rs2_busy, stall
    );

endinterface

// File: rtl/reg_file_rd_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register pending-write tracking and hazard detection.
// Optional build macro: REGFILE_PENDING_CNT_EN (2-bit in-flight counters
// instead of single busy bits).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   rs1_addr/rs1_used, rs2_addr/rs2_used : source operand selects
//   issue_valid, issue_rd          : destination being issued
//   wb_valid, wb_addr              : write-back in progress this cycle
//   rs1_busy, rs2_busy             : source still waiting on a producer
//   stall                          : RAW or WAW hazard, decode must hold
//   issue_ack                      : issue accepted this cycle
// -----------------------------------------------------------------------------
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = cpu_pkg::NREGS,
    parameter int AW    = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr,
    input  logic          rs1_used,
    input  logic [AW-1:0] rs2_addr,
    input  logic          rs2_used,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          stall,
    output logic          issue_ack
);

    sb_entry_t pending_q [NREGS];
    sb_entry_t pending_d [NREGS];

    logic [NREGS-1:0] set_v;
    logic [NREGS-1:0] clr_v;

    logic wb_rs1;
    logic wb_rs2;
    logic wb_rd;
    logic waw;

    assign wb_rs1 = wb_valid && (wb_addr == rs1_addr);
    assign wb_rs2 = wb_valid && (wb_addr == rs2_addr);
    assign wb_rd  = wb_valid && (wb_addr == issue_rd);

`ifdef REGFILE_PENDING_CNT_EN
    // With more than one producer in flight, the write-back landing now is
    // not the youngest one, so the source stays busy despite the bypass.
    assign rs1_busy = (pending_q[rs1_addr] > 2'd1) ||
                      ((pending_q[rs1_addr] == 2'd1) && !wb_rs1);
    assign rs2_busy = (pending_q[rs2_addr] > 2'd1) ||
                      ((pending_q[rs2_addr] == 2'd1) && !wb_rs2);
    assign waw      = (issue_rd != ZERO_REG) &&
                      (pending_q[issue_rd] == SB_MAX) && !wb_rd;
`else
    assign rs1_busy = pending_q[rs1_addr] && !wb_rs1;
    assign rs2_busy = pending_q[rs2_addr] && !wb_rs2;
    assign waw      = (issue_rd != ZERO_REG) && pending_q[issue_rd] && !wb_rd;
`endif

    assign stall     = (rs1_used && rs1_busy) ||
                       (rs2_used && rs2_busy) ||
                       (issue_valid && waw);
    assign issue_ack = issue_valid && !stall;

    // x0 is never set, so it can never report busy.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (issue_ack && (issue_rd != ZERO_REG)) begin
            set_v[issue_rd] = 1'b1;
        end
        if (wb_valid) begin
            clr_v[wb_addr] = 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pending_d[r] = pending_q[r];
`ifdef REGFILE_PENDING_CNT_EN
            // A write-back to an idle register does not underflow; so an
            // issue meeting such a write-back still counts as a new producer.
            case ({set_v[r], clr_v[r] && (pending_q[r] != 2'd0)})
                2'b10: begin
                    if (pending_q[r] != SB_MAX) begin
                        pending_d[r] = pending_q[r] + 2'd1;
                    end
                end
                2'b01:   pending_d[r] = pending_q[r] - 2'd1;
                default: pending_d[r] = pending_q[r];
            endcase
`else
            // Set wins over clear: the newly issued producer stays pending.
            if (set_v[r]) begin
                pending_d[r] = 1'b1;
            end else if (clr_v[r]) begin
                pending_d[r] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                pending_q[r] <= '0;
            end
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/reg_file_rd.sv
// -----------------------------------------------------------------------------
// reg_file_rd
// Integer register file read side: 32 x XLEN storage, two combinational read
// ports with same-cycle write-back bypass, one write-back port and a
// pending-write scoreboard that raises stall on RAW/WAW hazards.
// Optional build macro: REGFILE_PENDING_CNT_EN (handled in reg_scoreboard).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears storage and scoreboard;
//         a write-back in the reset cycle is discarded)
//   bus : reg_file_rd_if.slave -- operand reads, issue handshake,
//         write-back, busy flags and stall
// -----------------------------------------------------------------------------
module reg_file_rd
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS,
    parameter int AW    = cpu_pkg::AW
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_rd_if.slave bus
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_valid && (bus.wb_addr != ZERO_REG)) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // x0 is checked first so a write-back aimed at x0 is never bypassed.
    assign bus.rs1_data = (bus.rs1_addr == ZERO_REG) ? '0 :
                          (bus.wb_valid && (bus.wb_addr == bus.rs1_addr)) ? bus.wb_data :
                          regs_q[bus.rs1_addr];

    assign bus.rs2_data = (bus.rs2_addr == ZERO_REG) ? '0 :
                          (bus.wb_valid && (bus.wb_addr == bus.rs2_addr)) ? bus.wb_data :
                          regs_q[bus.rs2_addr];

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr    (bus.rs1_addr),
        .rs1_used    (bus.rs1_used),
        .rs2_addr    (bus.rs2_addr),
        .rs2_used    (bus.rs2_used),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .wb_valid    (bus.wb_valid),
        .wb_addr     (bus.wb_addr),
        .rs1_busy    (bus.rs1_busy),
        .rs2_busy    (bus.rs2_busy),
        .stall       (bus.stall),
        .issue_ack   (bus.issue_ack)
    );

endmodule

// File: tb/tb_reg_file_rd.sv
// -----------------------------------------------------------------------------
// tb_reg_file_rd
// Directed self-checking bench for reg_file_rd. Expected values are queued as
// each step is driven and popped when the outputs are sampled mid-cycle.
// Honours REGFILE_PENDING_CNT_EN for the multi-issue scenario.
// -----------------------------------------------------------------------------
module tb_reg_file_rd;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_file_rd_if bus ();

    reg_file_rd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.rs1_addr    = '0;
        bus.rs1_used    = 1'b0;
        bus.rs2_addr    = '0;
        bus.rs2_used    = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;

        // Reset for two cycles, then sweep every address on both ports.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            bus.rs1_addr = AW'(i);
            bus.rs2_addr = AW'(NREGS - 1 - i);
            push("rst_rs1_data", 32'h0);
            push("rst_rs2_data", 32'h0);
            push("rst_stall", 32'h0);
            push("rst_rs1_busy", 32'h0);
            push("rst_rs2_busy", 32'h0);
            #1;
            pop_chk(bus.rs1_data);
            pop_chk(bus.rs2_data);
            pop_chk(32'(bus.stall));
            pop_chk(32'(bus.rs1_busy));
            pop_chk(32'(bus.rs2_busy));
        end
        @(negedge clk);

        // Write-back to x5 bypassed in the same cycle, then read from storage.
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        bus.wb_data  = 32'hDEADBEEF;
        bus.rs1_addr = 5'd5;
        push("bypass_rs1_x5", 32'hDEADBEEF);
        #2;
        pop_chk(bus.rs1_data);
        tick();
        bus.wb_valid = 1'b0;
        push("stored_rs1_x5", 32'hDEADBEEF);
        #2;
        pop_chk(bus.rs1_data);

        // Write-back to x0 is neither bypassed nor stored.
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'h12345678;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd5;
        push("x0_no_bypass", 32'h0);
        push("x5_unaffected", 32'hDEADBEEF);
        #2;
        pop_chk(bus.rs1_data);
        pop_chk(bus.rs2_data);
        tick();
        bus.wb_valid = 1'b0;
        push("x0_after_wb", 32'h0);
        #2;
        pop_chk(bus.rs1_data);

        // Issue to x0 is always acked and never becomes pending.
        tick();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        push("x0_issue_ack", 32'h1);
        push("x0_issue_stall", 32'h0);
        #2;
        pop_chk(32'(bus.issue_ack));
        pop_chk(32'(bus.stall));
        tick();
        push("x0_issue_ack_again", 32'h1);
        #2;
        pop_chk(32'(bus.issue_ack));
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_used    = 1'b1;
        push("x0_not_busy", 32'h0);
        push("x0_no_stall", 32'h0);
        #2;
        pop_chk(32'(bus.rs1_busy));
        pop_chk(32'(bus.stall));

        // RAW on x7: issue, stall on read, cleared by the matching write-back.
        tick();
        bus.rs1_used    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        push("x7_issue_ack", 32'h1);
        #2;
        pop_chk(32'(bus.issue_ack));
        tick();
        bus.issue_valid = 1'b0;
        bus.rs2_addr    = 5'd7;
        bus.rs2_used    = 1'b1;
        push("raw_x7_stall", 32'h1);
        push("raw_x7_busy", 32'h1);
        #2;
        pop_chk(32'(bus.stall));
        pop_chk(32'(bus.rs2_busy));
        tick();
        push("raw_x7_still_stall", 32'h1);
        #2;
        pop_chk(32'(bus.stall));
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd7;
        bus.wb_data  = 32'h55;
        push("wb_x7_stall", 32'h0);
        push("wb_x7_busy", 32'h0);
        push("wb_x7_data", 32'h55);
        #1;
        pop_chk(32'(bus.stall));
        pop_chk(32'(bus.rs2_busy));
        pop_chk(bus.rs2_data);
        tick();
        bus.wb_valid = 1'b0;
        push("after_wb_x7_busy", 32'h0);
        push("after_wb_x7_data", 32'h55);
        push("after_wb_x7_stall", 32'h0);
        #2;
        pop_chk(32'(bus.rs2_busy));
        pop_chk(bus.rs2_data);
        pop_chk(32'(bus.stall));

        // WAW on x9.
        tick();
        bus.rs2_used    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        push("x9_issue1_ack", 32'h1);
        #2;
        pop_chk(32'(bus.issue_ack));
`ifdef REGFILE_PENDING_CNT_EN
        tick();
        push("x9_issue2_ack", 32'h1);
        #2;
        pop_chk(32'(bus.issue_ack));
        tick();
        push("x9_issue3_ack", 32'h1);
        #2;
        pop_chk(32'(bus.issue_ack));
        tick();
        push("x9_issue4_stall", 32'h1);
        push("x9_issue4_ack", 32'h0);
        #2;
        pop_chk(32'(bus.stall));
        pop_chk(32'(bus.issue_ack));
        tick();
        // Full counter plus matching write-back: accepted, count unchanged.
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd9;
        bus.wb_data  = 32'h99;
        push("x9_issue_wb_ack", 32'h1);
        #2;
        pop_chk(32'(bus.issue_ack));
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd9;
        bus.rs1_used    = 1'b1;
        push("x9_cnt3_wb_busy", 32'h1);
        push("x9_cnt3_wb_stall", 32'h1);
        #2;
        pop_chk(32'(bus.rs1_busy));
        pop_chk(32'(bus.stall));
        tick();
        push("x9_cnt2_wb_busy", 32'h1);
        #2;
        pop_chk(32'(bus.rs1_busy));
        tick();
        push("x9_cnt1_wb_busy", 32'h0);
        #2;
        pop_chk(32'(bus.rs1_busy));
        tick();
        bus.wb_valid = 1'b0;
        push("x9_drained_busy", 32'h0);
        #2;
        pop_chk(32'(bus.rs1_busy));
`else
        tick();
        push("x9_waw_stall", 32'h1);
        push("x9_waw_ack", 32'h0);
        #2;
        pop_chk(32'(bus.stall));
        pop_chk(32'(bus.issue_ack));
        tick();
        // Issue meets the retiring write-back: accepted and stays pending.
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd9;
        bus.wb_data  = 32'h99;
        push("x9_issue_wb_ack", 32'h1);
        #2;
        pop_chk(32'(bus.issue_ack));
        tick();
        bus.wb_valid    = 1'b0;
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd9;
        bus.rs1_used    = 1'b1;
        push("x9_set_wins_busy", 32'h1);
        push("x9_set_wins_stall", 32'h1);
        #2;
        pop_chk(32'(bus.rs1_busy));
        pop_chk(32'(bus.stall));
        tick();
        bus.wb_valid = 1'b1;
        tick();
        bus.wb_valid = 1'b0;
        push("x9_cleared_busy", 32'h0);
        #2;
        pop_chk(32'(bus.rs1_busy));
`endif
        // Write-back to an idle register: data updates, nothing pending.
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd9;
        bus.wb_data  = 32'hA5A5_0009;
        tick();
        bus.wb_valid = 1'b0;
        push("x9_idle_wb_busy", 32'h0);
        push("x9_idle_wb_data", 32'hA5A5_0009);
        #2;
        pop_chk(32'(bus.rs1_busy));
        pop_chk(bus.rs1_data);

        // Reset with pending x3/x4 and a write-back in the reset cycle.
        tick();
        bus.rs1_used = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd3;
        bus.wb_data  = 32'h0000_AAAA;
        tick();
        bus.wb_addr  = 5'd4;
        bus.wb_data  = 32'h0000_BBBB;
        tick();
        bus.wb_valid    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        tick();
        bus.issue_rd = 5'd4;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd3;
        bus.rs2_addr    = 5'd4;
        push("pre_rst_x3_busy", 32'h1);
        push("pre_rst_x4_busy", 32'h1);
        push("pre_rst_x4_data", 32'h0000_BBBB);
        #2;
        pop_chk(32'(bus.rs1_busy));
        pop_chk(32'(bus.rs2_busy));
        pop_chk(bus.rs2_data);
        tick();
        rst          = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd3;
        bus.wb_data  = 32'h77;
        tick();
        rst          = 1'b0;
        bus.wb_valid = 1'b0;
        bus.rs1_used = 1'b1;
        bus.rs2_used = 1'b1;
        push("post_rst_x3_data", 32'h0);
        push("post_rst_x4_data", 32'h0);
        push("post_rst_x3_busy", 32'h0);
        push("post_rst_x4_busy", 32'h0);
        push("post_rst_stall", 32'h0);
        #2;
        pop_chk(bus.rs1_data);
        pop_chk(bus.rs2_data);
        pop_chk(32'(bus.rs1_busy));
        pop_chk(32'(bus.rs2_busy));
        pop_chk(32'(bus.stall));
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        push("post_rst_issue_x3_ack", 32'h1);
        #1;
        pop_chk(32'(bus.issue_ack));
        tick();
        bus.issue_valid = 1'b0;
        bus.rs2_used    = 1'b0;

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
